// File: rtl/ball_controller.sv
// Pong ball engine: ball position/direction, serve and score sequencing.
// Every state change other than serve and reset happens on the frame_tick cycle.
module ball_controller #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int SPEED_X        = 2,
  parameter int SPEED_Y        = 1,
  parameter int SCORE_HOLD     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       pause,
  input  logic [8:0] left_pad_y,
  input  logic [8:0] right_pad_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       score_left,
  output logic       score_right,
  output logic [1:0] state
);

  localparam int HOLD_W = $clog2(SCORE_HOLD + 1);

  // All geometry compares use 11-bit unsigned values so sums never wrap.
  localparam logic [10:0] SW     = 11'(SCREEN_W);
  localparam logic [10:0] SH     = 11'(SCREEN_H);
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] SX     = 11'(SPEED_X);
  localparam logic [10:0] SY     = 11'(SPEED_Y);
  localparam logic [10:0] FACE_R = 11'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [10:0] FACE_L = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] CX     = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0] CY     = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MOVING = 2'b01,
    SCORED = 2'b10
  } ballState_e;

  ballState_e        curState, nextState;
  logic [9:0]        ballX, nextX;
  logic [8:0]        ballY, nextY;
  logic              dirX, nextDirX;   // 1 = moving right
  logic              dirY, nextDirY;   // 1 = moving down
  logic [HOLD_W-1:0] holdCnt, nextHold;
  logic              scoreL, nextScoreL;
  logic              scoreR, nextScoreR;

  logic [10:0] x11, y11, lPad11, rPad11;
  logic        overlapL, overlapR;

  assign x11    = {1'b0, ballX};
  assign y11    = {2'b00, ballY};
  assign lPad11 = {2'b00, left_pad_y};
  assign rPad11 = {2'b00, right_pad_y};

  assign overlapL = (y11 + BS >= lPad11) && (y11 <= lPad11 + PH);
  assign overlapR = (y11 + BS >= rPad11) && (y11 <= rPad11 + PH);

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= IDLE;
      ballX    <= 10'(CX);
      ballY    <= 9'(CY);
      dirX     <= 1'b1;
      dirY     <= 1'b1;
      holdCnt  <= '0;
      scoreL   <= 1'b0;
      scoreR   <= 1'b0;
    end else begin
      curState <= nextState;
      ballX    <= nextX;
      ballY    <= nextY;
      dirX     <= nextDirX;
      dirY     <= nextDirY;
      holdCnt  <= nextHold;
      scoreL   <= nextScoreL;
      scoreR   <= nextScoreR;
    end
  end

  always_comb begin
    nextState  = curState;
    nextX      = ballX;
    nextY      = ballY;
    nextDirX   = dirX;
    nextDirY   = dirY;
    nextHold   = holdCnt;
    nextScoreL = 1'b0;
    nextScoreR = 1'b0;

    case (curState)
      IDLE: begin
        nextX = 10'(CX);
        nextY = 9'(CY);
        if (serve) nextState = MOVING;
      end

      MOVING: begin
        if (frame_tick && !pause) begin
          if (dirY) begin
            if (y11 + BS + SY > SH) begin
              nextY    = 9'(SH - BS);
              nextDirY = 1'b0;
            end else begin
              nextY = 9'(y11 + SY);
            end
          end else begin
            if (y11 < SY) begin
              nextY    = '0;
              nextDirY = 1'b1;
            end else begin
              nextY = 9'(y11 - SY);
            end
          end

          // On a score the ball reverses so the next serve heads back at the scorer.
          if (dirX) begin
            if (x11 <= FACE_R && x11 + SX >= FACE_R && overlapR) begin
              nextX    = 10'(FACE_R);
              nextDirX = 1'b0;
            end else if (x11 + BS + SX > SW) begin
              nextScoreL = 1'b1;
              nextState  = SCORED;
              nextDirX   = 1'b0;
              nextHold   = '0;
            end else begin
              nextX = 10'(x11 + SX);
            end
          end else begin
            if (x11 >= FACE_L && x11 <= FACE_L + SX && overlapL) begin
              nextX    = 10'(FACE_L);
              nextDirX = 1'b1;
            end else if (x11 < SX) begin
              nextScoreR = 1'b1;
              nextState  = SCORED;
              nextDirX   = 1'b1;
              nextHold   = '0;
            end else begin
              nextX = 10'(x11 - SX);
            end
          end
        end
      end

      SCORED: begin
        if (frame_tick) begin
          if (holdCnt == HOLD_LAST) begin
            nextState = IDLE;
            nextX     = 10'(CX);
            nextY     = 9'(CY);
            nextHold  = '0;
          end else begin
            nextHold = holdCnt + 1'b1;
          end
        end
      end

      default: nextState = IDLE;
    endcase
  end

  assign ball_x      = ballX;
  assign ball_y      = ballY;
  assign score_left  = scoreL;
  assign score_right = scoreR;
  assign state       = curState;

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: directed scenarios with literal expectations,
// then random frame/serve/pause/paddle traffic against a behavioural model.
module tb_ball_controller;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       serve;
  logic       pause;
  logic [8:0] left_pad_y;
  logic [8:0] right_pad_y;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       score_left;
  logic       score_right;
  logic [1:0] state;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  // Model state: plain integers in screen pixels.
  int mState, mx, my, mdx, mdy, mhold, msl, msr;
  int nx, ny, ndx, ndy;

  ball_controller dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .serve       (serve),
    .pause       (pause),
    .left_pad_y  (left_pad_y),
    .right_pad_y (right_pad_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score_left  (score_left),
    .score_right (score_right),
    .state       (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: evaluates the game rules on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      mState = 0; mx = 316; my = 236; mdx = 1; mdy = 1; mhold = 0; msl = 0; msr = 0;
    end else begin
      msl = 0; msr = 0;
      if (mState == 0) begin
        mx = 316; my = 236;
        if (serve) mState = 1;
      end else if (mState == 1) begin
        if (frame_tick && !pause) begin
          ny = my; ndy = mdy; nx = mx; ndx = mdx;
          if (mdy == 1) begin
            if (my + 9 > 480) begin ny = 472; ndy = 0; end
            else ny = my + 1;
          end else begin
            if (my < 1) begin ny = 0; ndy = 1; end
            else ny = my - 1;
          end
          if (mdx == 1) begin
            if (mx <= 608 && mx + 2 >= 608 &&
                my + 8 >= int'(right_pad_y) && my <= int'(right_pad_y) + 64) begin
              nx = 608; ndx = 0;
            end else if (mx + 10 > 640) begin
              msl = 1; mState = 2; mhold = 0; ndx = 0;
            end else nx = mx + 2;
          end else begin
            if (mx >= 24 && mx <= 26 &&
                my + 8 >= int'(left_pad_y) && my <= int'(left_pad_y) + 64) begin
              nx = 24; ndx = 1;
            end else if (mx < 2) begin
              msr = 1; mState = 2; mhold = 0; ndx = 1;
            end else nx = mx - 2;
          end
          mx = nx; my = ny; mdx = ndx; mdy = ndy;
        end
      end else begin
        if (frame_tick) begin
          mhold++;
          if (mhold == 60) begin
            mState = 0; mx = 316; my = 236; mhold = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("model_x", ball_x, mx);
      chk("model_y", ball_y, my);
      chk("model_state", state, mState);
      chk("model_score_left", score_left, msl);
      chk("model_score_right", score_right, msr);
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic do_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; serve = 1'b0; pause = 1'b0;
    left_pad_y = 9'd0; right_pad_y = 9'd400;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    chk("reset_x", ball_x, 316);
    chk("reset_y", ball_y, 236);
    chk("reset_state", state, 0);
    chk("reset_pulses", {score_left, score_right}, 0);
    reset = 1'b0;

    // Straight flight with paddles out of the way
    do_serve();
    ticks(10);
    chk("t2_x", ball_x, 336);
    chk("t2_y", ball_y, 246);
    chk("t2_state", state, 1);

    // Reset while moving
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t1_x", ball_x, 316);
    chk("t1_y", ball_y, 236);
    chk("t1_state", state, 0);
    reset = 1'b0;

    // Right paddle bounce
    right_pad_y = 9'd350; left_pad_y = 9'd0;
    do_serve();
    ticks(146);
    chk("t3_bounce_x", ball_x, 608);
    ticks(1);
    chk("t3_after_x", ball_x, 606);
    chk("t3_after_y", ball_y, 383);
    do_reset();

    // Right miss -> score_left, hold, recentre, reversed serve
    right_pad_y = 9'd0;
    do_serve();
    ticks(158);
    chk("t4_edge_x", ball_x, 632);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    chk("t4_score_left", score_left, 1);
    chk("t4_scored_state", state, 2);
    chk("t4_frozen_x", ball_x, 632);
    @(negedge clk);
    chk("t4_pulse_gone", score_left, 0);
    do_serve();
    chk("t4_serve_ignored", state, 2);
    ticks(59);
    chk("t4_still_scored", state, 2);
    ticks(1);
    chk("t4_idle", state, 0);
    chk("t4_centre_x", ball_x, 316);
    chk("t4_centre_y", ball_y, 236);
    do_serve();
    ticks(1);
    chk("t4_reserve_x", ball_x, 314);
    chk("t4_reserve_y", ball_y, 237);
    do_reset();

    // Paddles track the ball, bottom-wall bounce
    do_serve();
    for (int i = 1; i <= 238; i++) begin
      @(negedge clk);
      left_pad_y  = 9'((my >= 28) ? my - 28 : 0);
      right_pad_y = 9'((my >= 28) ? my - 28 : 0);
      frame_tick  = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      if (i == 236) chk("t5_y236", ball_y, 472);
      if (i == 237) chk("t5_y237", ball_y, 472);
      if (i == 238) chk("t5_y238", ball_y, 471);
    end
    chk("t5_state", state, 1);
    do_reset();

    // Pause holds the ball; serve with a coincident tick does not move it
    do_serve();
    ticks(3);
    pause = 1'b1;
    ticks(5);
    chk("t6_pause_x", ball_x, 322);
    chk("t6_pause_y", ball_y, 239);
    pause = 1'b0;
    do_reset();
    @(negedge clk); serve = 1'b1; frame_tick = 1'b1;
    @(negedge clk); serve = 1'b0; frame_tick = 1'b0;
    chk("t6_serve_state", state, 1);
    chk("t6_serve_x", ball_x, 316);
    chk("t6_serve_y", ball_y, 236);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 2) == 0);
      serve      = ($urandom_range(0, 19) == 0);
      pause      = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 15) == 0) left_pad_y  = 9'($urandom_range(0, 416));
      if ($urandom_range(0, 15) == 0) right_pad_y = 9'($urandom_range(0, 416));
    end
    @(negedge clk);
    frame_tick = 1'b0; serve = 1'b0; pause = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
